// File: rtl/message_scroller_if.sv
// message_scroller_if: control, write port and window outputs of the message scroller.
interface message_scroller_if;
  logic en_scroll;
  logic dir;
  logic wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] char3;
  logic [3:0] char2;
  logic [3:0] char1;
  logic [3:0] char0;
  logic step;
  modport master (
    output en_scroll, dir, wr_en, wr_addr, wr_data,
    input char3, char2, char1, char0, step
  );
  modport slave (
    input en_scroll, dir, wr_en, wr_addr, wr_data,
    output char3, char2, char1, char0, step
  );
endinterface

// File: rtl/message_scroller.sv
// message_scroller: 16-entry message with a registered 4-character sliding window that scrolls periodically.
module message_scroller #(
  parameter int SCROLL_CYCLES = 16,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic reset,
  message_scroller_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(SCROLL_CYCLES - 1);
  logic [3:0] mem [16];
  logic [3:0] ptr;
  logic [CNT_WIDTH-1:0] cnt;
  logic tc;
  assign tc = bus.en_scroll && cnt == LAST;
  // window reads pre-edge ptr/mem, giving one cycle of latency after any update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'(i);
      ptr <= '0;
      cnt <= '0;
      bus.step <= 1'b0;
      bus.char3 <= 4'h0;
      bus.char2 <= 4'h1;
      bus.char1 <= 4'h2;
      bus.char0 <= 4'h3;
    end else begin
      cnt <= !bus.en_scroll ? cnt : tc ? '0 : cnt + 1'b1;
      bus.step <= tc;
      if (tc) ptr <= bus.dir ? ptr - 4'd1 : ptr + 4'd1;
      if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
      bus.char3 <= mem[ptr];
      bus.char2 <= mem[ptr + 4'd1];
      bus.char1 <= mem[ptr + 4'd2];
      bus.char0 <= mem[ptr + 4'd3];
    end
  end
endmodule

// File: tb/tb_message_scroller.sv
// tb_message_scroller: directed and randomized checks against a position/enabled-clock reference model.
module tb_message_scroller;
  localparam int P = 4;
  logic clk;
  logic reset;
  message_scroller_if bus ();
  message_scroller #(.SCROLL_CYCLES(P), .CNT_WIDTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  int checks = 0;
  int errors = 0;
  logic [3:0] m_mem [16];
  int pos;
  int en_count;
  int model_steps;
  int obs_steps;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic logic [15:0] window();
    return {bus.char3, bus.char2, bus.char1, bus.char0};
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 4'(i);
    pos = 0;
    en_count = 0;
    model_steps = 0;
    obs_steps = 0;
  endtask
  task automatic tick();
    logic [15:0] exp_c;
    logic exp_s;
    @(posedge clk);
    exp_c = {m_mem[pos], m_mem[(pos + 1) % 16], m_mem[(pos + 2) % 16], m_mem[(pos + 3) % 16]};
    if (bus.en_scroll) en_count++;
    exp_s = bus.en_scroll && (en_count % P == 0);
    if (exp_s) begin
      pos = bus.dir ? (pos + 15) % 16 : (pos + 1) % 16;
      model_steps++;
    end
    if (bus.wr_en) m_mem[bus.wr_addr] = bus.wr_data;
    #1;
    chk("window", window(), exp_c);
    chk("step", {15'd0, bus.step}, {15'd0, exp_s});
    if (bus.step) obs_steps++;
  endtask
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("reset_window", window(), 16'h0123);
    chk("reset_step", {15'd0, bus.step}, 16'd0);
    #2;
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    bus.en_scroll = 1'b0;
    bus.dir = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = 4'h0;
    bus.wr_data = 4'h0;
    model_reset();
    #2;
    chk("init_window", window(), 16'h0123);
    chk("init_step", {15'd0, bus.step}, 16'd0);
    #1;
    reset = 1'b0;
    // scroll to ptr 5 and part way into the next period, then reset mid-count
    bus.en_scroll = 1'b1;
    for (int i = 0; i < 22; i++) tick();
    do_reset();
    for (int i = 0; i < 64; i++) tick();
    chk("steps_64", 16'(obs_steps), 16'd16);
    chk("steps_model", 16'(obs_steps), 16'(model_steps));
    tick();
    chk("wrap_home", window(), 16'h0123);
    // right scroll from reset
    do_reset();
    bus.dir = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("right_first", window(), 16'hF012);
    for (int i = 0; i < 4; i++) tick();
    chk("right_second", window(), 16'hEF01);
    // pause with cnt = 2
    do_reset();
    bus.dir = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    bus.en_scroll = 1'b0;
    bus.dir = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.dir = 1'b0;
    bus.en_scroll = 1'b1;
    tick();
    chk("resume_no_step", {15'd0, bus.step}, 16'd0);
    tick();
    chk("resume_step", {15'd0, bus.step}, 16'd1);
    // single write at ptr 0
    do_reset();
    bus.en_scroll = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_addr = 4'h1;
    bus.wr_data = 4'h9;
    tick();
    bus.wr_en = 1'b0;
    tick();
    chk("write_char2", window(), 16'h0923);
    // write coinciding with a step
    do_reset();
    bus.en_scroll = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.wr_en = 1'b1;
    bus.wr_addr = 4'h4;
    bus.wr_data = 4'hA;
    tick();
    bus.wr_en = 1'b0;
    tick();
    chk("write_with_step", window(), 16'h123A);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.en_scroll = ($urandom_range(3) != 0);
      bus.dir = ($urandom_range(7) == 0) ? ~bus.dir : bus.dir;
      bus.wr_en = ($urandom_range(3) == 0);
      bus.wr_addr = 4'($urandom);
      bus.wr_data = 4'($urandom);
      if ($urandom_range(59) == 0) do_reset();
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/message_scroller.md
Name: message_scroller

Overview:
- Upstream character source for the four-digit 7-segment driver path.
- Holds a 16-entry message of 4-bit characters and presents a sliding 4-character window (char3..char0) to the display fsm.
- Advances the window one position every SCROLL_CYCLES enabled clocks, left or right, with wrap-around.
- Message entries can be rewritten at run time through a single-cycle write port.

Parameters:
- SCROLL_CYCLES, 16, number of clk cycles between window steps; legal range 2 to 2^CNT_WIDTH.
- CNT_WIDTH, 16, width of the step-period counter.

Ports:
- clk  input  1  system clock, same domain as the display fsm.
- reset  input  1  asynchronous, active-high reset.
- en_scroll  input  1  level; 1 = period counter runs, 0 = counter and window frozen.
- dir  input  1  0 = scroll left (ptr increments), 1 = scroll right (ptr decrements).
- wr_en  input  1  single-cycle message write strobe.
- wr_addr  input  4  message entry to write.
- wr_data  input  4  character value to write.
- char3  output  4  leftmost displayed character (feeds digit an3).
- char2  output  4  second character.
- char1  output  4  third character.
- char0  output  4  rightmost character (digit an0).
- step  output  1  one-cycle pulse on the clock where the window pointer moves.

Behaviour:
- State: mem[0..15] (4 bits each), ptr[3:0], cnt[CNT_WIDTH-1:0], registered char3..char0, registered step.
- Reset (asynchronous, effective immediately, including mid-operation):
  - mem[i] = i; ptr = 0; cnt = 0; step = 0.
  - char3 = 4'h0, char2 = 4'h1, char1 = 4'h2, char0 = 4'h3.
- Period counter:
  - If en_scroll = 1 and cnt == SCROLL_CYCLES-1: cnt wraps to 0 and a step occurs.
  - Otherwise, if en_scroll = 1, cnt increments.
  - If en_scroll = 0, cnt holds its value; it is not cleared.
- Step:
  - ptr = ptr+1 mod 16 when dir = 0; ptr = ptr-1 mod 16 when dir = 1.
  - The step output is 1 for exactly the cycle following the terminal-count edge, i.e. registered together with the new ptr.
  - dir is sampled only at the step edge; changing dir between steps never moves ptr.
- Window outputs, registered every clock:
  - char3 = mem[ptr], char2 = mem[ptr+1], char1 = mem[ptr+2], char0 = mem[ptr+3].
  - All indices are mod 16.
  - Outputs reflect ptr and mem as they were after the previous edge, so there is one cycle of latency from any ptr or mem update to the char outputs.
- Write:
  - On an edge with wr_en = 1, mem[wr_addr] <= wr_data.
  - The new value appears on the affected char output at the following edge.
  - No ready or busy signalling; a write is accepted every cycle.
- Simultaneous write and step: both take effect on the same edge. The next output edge uses the new ptr and the new mem contents.
- Wrap-around:
  - ptr 15 -> 0 (left) and 0 -> 15 (right) with no stall.
  - The window spanning the end of the message (e.g. ptr = 14 gives mem 14, 15, 0, 1) is legal.
- No combinational path from any input to any output.

Test Plan (SCROLL_CYCLES = 4):
- Reset asserted mid-count with ptr = 5 -> immediately char3..char0 = 0,1,2,3, step = 0, ptr = 0. After release with en_scroll = 1, dir = 0: step pulses every 4th clock, and the window reads 1,2,3,4 one cycle after the first step.
- en_scroll = 1, dir = 0 for 64 clocks -> 16 step pulses; the window passes E,F,0,1 at ptr = 14; ptr returns to 0 and the window to 0,1,2,3.
- dir = 1 from reset -> the first step gives ptr = 15 and window F,0,1,2; the second step gives E,F,0,1.
- en_scroll dropped with cnt = 2 for 10 clocks, then re-raised -> no step while low; the next step occurs exactly 2 enabled clocks after re-enable (cnt 2 -> 3 -> step).
- wr_en with wr_addr = 1, wr_data = 4'h9, with ptr = 0 -> char2 = 9 one clock after the write edge; char3, char1, char0 are unchanged.
- Write to mem[4] = 4'hA on the same edge as a step from ptr 0 to ptr 1 -> next outputs are 1,2,3,A.
